// File: rtl/lvt_write_tracker.sv
// Live value table for the 4-port LVT cache: records the last writer port per word
// and serves 4 registered lookups. Optional write-to-read bypass: LVT_WR_BYPASS_EN.
module lvt_write_tracker #(
  parameter int ADDR_W  = 8,
  parameter int ENTRY_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en_0,
  input  logic               wr_en_1,
  input  logic               wr_en_2,
  input  logic               wr_en_3,
  input  logic [ADDR_W-1:0]  wr_addr_0,
  input  logic [ADDR_W-1:0]  wr_addr_1,
  input  logic [ADDR_W-1:0]  wr_addr_2,
  input  logic [ADDR_W-1:0]  wr_addr_3,
  input  logic [ADDR_W-1:0]  rd_addr_0,
  input  logic [ADDR_W-1:0]  rd_addr_1,
  input  logic [ADDR_W-1:0]  rd_addr_2,
  input  logic [ADDR_W-1:0]  rd_addr_3,
  output logic [ENTRY_W-1:0] rd_entry_0,
  output logic [ENTRY_W-1:0] rd_entry_1,
  output logic [ENTRY_W-1:0] rd_entry_2,
  output logic [ENTRY_W-1:0] rd_entry_3,
  input  logic               clear_req,
  output logic               busy
);

  localparam int                 DEPTH   = 1 << ADDR_W;
  localparam int                 NPORT   = 4;
  localparam logic [ADDR_W-1:0]  CNT_MAX = '1;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    cnt_q, cnt_d;
  logic [ENTRY_W-1:0]   lvt_q [DEPTH];
  logic [ENTRY_W-1:0]   lvt_d [DEPTH];
  logic [ENTRY_W-1:0]   rd_entry_q [NPORT];
  logic [ENTRY_W-1:0]   rd_entry_d [NPORT];

  logic                 wr_en_a   [NPORT];
  logic [ADDR_W-1:0]    wr_addr_a [NPORT];
  logic [ADDR_W-1:0]    rd_addr_a [NPORT];

  assign wr_en_a   = '{wr_en_0, wr_en_1, wr_en_2, wr_en_3};
  assign wr_addr_a = '{wr_addr_0, wr_addr_1, wr_addr_2, wr_addr_3};
  assign rd_addr_a = '{rd_addr_0, rd_addr_1, rd_addr_2, rd_addr_3};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_MAX) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  // Later ports overwrite earlier ones, so the highest-indexed writer wins a conflict.
  always_comb begin
    lvt_d = lvt_q;
    if (busy) begin
      lvt_d[cnt_q] = '0;
    end else begin
      for (int k = 0; k < NPORT; k++) begin
        if (wr_en_a[k]) begin
          lvt_d[wr_addr_a[k]] = ENTRY_W'(k);
        end
      end
    end
  end

  // Table contents are not reset; the sweep rewrites every entry.
  always_ff @(posedge clk) begin
    lvt_q <= lvt_d;
  end

  always_comb begin
    for (int k = 0; k < NPORT; k++) begin
      rd_entry_d[k] = '0;
      if (!busy) begin
        rd_entry_d[k] = lvt_q[rd_addr_a[k]];
`ifdef LVT_WR_BYPASS_EN
        for (int j = 0; j < NPORT; j++) begin
          if (wr_en_a[j] && (wr_addr_a[j] == rd_addr_a[k])) begin
            rd_entry_d[k] = ENTRY_W'(j);
          end
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NPORT; k++) begin
        rd_entry_q[k] <= '0;
      end
    end else begin
      rd_entry_q <= rd_entry_d;
    end
  end

  assign rd_entry_0 = rd_entry_q[0];
  assign rd_entry_1 = rd_entry_q[1];
  assign rd_entry_2 = rd_entry_q[2];
  assign rd_entry_3 = rd_entry_q[3];

endmodule

// File: tb/tb_lvt_write_tracker.sv
// Directed bench for lvt_write_tracker with ADDR_W=4 (16-entry table).
module tb_lvt_write_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear_req;
  logic       busy;
  logic       wr_en    [4];
  logic [3:0] wr_addr  [4];
  logic [3:0] rd_addr  [4];
  logic [1:0] rd_entry [4];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  lvt_write_tracker #(.ADDR_W(4), .ENTRY_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en_0    (wr_en[0]),
    .wr_en_1    (wr_en[1]),
    .wr_en_2    (wr_en[2]),
    .wr_en_3    (wr_en[3]),
    .wr_addr_0  (wr_addr[0]),
    .wr_addr_1  (wr_addr[1]),
    .wr_addr_2  (wr_addr[2]),
    .wr_addr_3  (wr_addr[3]),
    .rd_addr_0  (rd_addr[0]),
    .rd_addr_1  (rd_addr[1]),
    .rd_addr_2  (rd_addr[2]),
    .rd_addr_3  (rd_addr[3]),
    .rd_entry_0 (rd_entry[0]),
    .rd_entry_1 (rd_entry[1]),
    .rd_entry_2 (rd_entry[2]),
    .rd_entry_3 (rd_entry[3]),
    .clear_req  (clear_req),
    .busy       (busy)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_idle();
    for (int k = 0; k < 4; k++) begin
      wr_en[k]   = 1'b0;
      wr_addr[k] = 4'h0;
    end
  endtask

  // Count cycles until busy falls, bounded.
  task automatic count_busy(input string tag, input int exp);
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk(tag, n, exp);
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 16; a++) begin
      for (int k = 0; k < 4; k++) rd_addr[k] = 4'((a + 5 * k) % 16);
      tick();
      for (int k = 0; k < 4; k++) chk($sformatf("%s_a%0d_p%0d", tag, a, k), rd_entry[k], 0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    clear_req = 1'b0;
    wr_idle();
    for (int k = 0; k < 4; k++) rd_addr[k] = 4'h0;
    tick();
    tick();
    chk("rst_busy", busy, 1);
    for (int k = 0; k < 4; k++) chk($sformatf("rst_entry%0d", k), rd_entry[k], 0);

    // Reset sweep: 16 busy cycles after release.
    reset = 1'b0;
    count_busy("rst_sweep_len", 16);
    read_all_zero("post_rst");

    // Single writes.
    wr_en[2] = 1'b1; wr_addr[2] = 4'h5;
    tick();
    wr_idle();
    wr_en[1] = 1'b1; wr_addr[1] = 4'h9;
    tick();
    wr_idle();
    rd_addr[0] = 4'h5; rd_addr[3] = 4'h9;
    tick();
    chk("single_p2", rd_entry[0], 2);
    chk("single_p1", rd_entry[3], 1);

    // Conflicts: highest enabled port wins.
    wr_en[0] = 1'b1; wr_en[1] = 1'b1; wr_en[3] = 1'b1;
    wr_addr[0] = 4'hA; wr_addr[1] = 4'hA; wr_addr[3] = 4'hA;
    tick();
    wr_idle();
    rd_addr[2] = 4'hA;
    tick();
    chk("conflict_013", rd_entry[2], 3);
    wr_en[0] = 1'b1; wr_en[2] = 1'b1;
    wr_addr[0] = 4'hA; wr_addr[2] = 4'hA;
    tick();
    wr_idle();
    tick();
    chk("conflict_02", rd_entry[2], 2);

    // Read-during-write.
    wr_en[1] = 1'b1; wr_addr[1] = 4'h3;
    tick();
    wr_idle();
    rd_addr[1] = 4'h3;
    tick();
    chk("rdw_pre", rd_entry[1], 1);
    wr_en[2] = 1'b1; wr_addr[2] = 4'h3;
    tick();
    wr_idle();
`ifdef LVT_WR_BYPASS_EN
    chk("rdw_same", rd_entry[1], 2);
`else
    chk("rdw_same", rd_entry[1], 1);
`endif
    tick();
    chk("rdw_after", rd_entry[1], 2);

    // clear_req with writes during the sweep.
    wr_en[3] = 1'b1; wr_addr[3] = 4'h0;
    tick();
    wr_addr[3] = 4'hF;
    tick();
    wr_idle();
    rd_addr[0] = 4'h0; rd_addr[1] = 4'hF;
    tick();
    chk("pre_clr_00", rd_entry[0], 3);
    chk("pre_clr_0f", rd_entry[1], 3);
    for (int k = 0; k < 4; k++) rd_addr[k] = 4'h2;
    clear_req = 1'b1;
    wr_en[0] = 1'b1; wr_addr[0] = 4'h1;
    tick();
    clear_req = 1'b0;
    chk("clr_busy", busy, 1);
    rd_addr[0] = 4'h0; rd_addr[1] = 4'hF; rd_addr[2] = 4'h3; rd_addr[3] = 4'h5;
    for (int k = 0; k < 4; k++) begin
      wr_en[k] = 1'b1;
      wr_addr[k] = 4'(5 + k);
    end
    begin
      int n;
      n = 0;
      while (busy && n < 40) begin
        tick();
        n++;
        if (busy) begin
          chk($sformatf("clr_hold0_c%0d", n), rd_entry[0], 0);
          chk($sformatf("clr_hold3_c%0d", n), rd_entry[3], 0);
        end
      end
      chk("clr_sweep_len", n, 16);
    end
    wr_idle();
    read_all_zero("post_clr");

    // Reset during a sweep restarts it.
    wr_en[3] = 1'b1; wr_addr[3] = 4'hC;
    tick();
    wr_idle();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("mid_busy_pre", busy, 1);
    reset = 1'b1;
    tick();
    tick();
    chk("mid_rst_busy", busy, 1);
    reset = 1'b0;
    count_busy("mid_sweep_len", 16);
    rd_addr[0] = 4'hC;
    tick();
    chk("mid_cleared", rd_entry[0], 0);
    wr_en[1] = 1'b1; wr_addr[1] = 4'hC;
    tick();
    wr_idle();
    tick();
    chk("mid_write_ok", rd_entry[0], 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
